// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad BPM entry block: key codes, debounce
// states and the physical column/row to key-code map of the 4x4 Pmod keypad.
package keypad_pkg;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        CAND,
        PRESSED,
        REL
    } debounce_state_e;

    function automatic logic [3:0] keyMap(input logic [1:0] colIdx, input logic [1:0] rowIdx);
        logic [3:0] code;
        case ({colIdx, rowIdx})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h4;
            4'b00_10: code = 4'h7;
            4'b00_11: code = 4'h0;
            4'b01_00: code = 4'h2;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h8;
            4'b01_11: code = 4'hF;
            4'b10_00: code = 4'h3;
            4'b10_01: code = 4'h6;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hE;
            4'b11_00: code = 4'hA;
            4'b11_01: code = 4'hB;
            4'b11_10: code = 4'hC;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner, row synchroniser, per-scan ghost-rejecting decode and
// press/release debounce for the 4x4 keypad; emits one pulse per accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] col_o,
    input  logic [3:0] row_i,
    output logic       keyValid_o,
    output logic [3:0] keyCode_o
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    logic [3:0]       rowMeta_q, rowSync_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       colIdx_q;
    logic [1:0]       hits_q;
    logic [3:0]       codeAcc_q;

    debounce_state_e  state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       cand_q;
    logic             keyValid_q;
    logic [3:0]       keyCode_q;

    logic [3:0] lowBits;
    logic [2:0] colLows;
    logic [2:0] hitsSum;
    logic [1:0] rowIdx;
    logic [1:0] hitsNext;
    logic [3:0] codeNext;
    logic       scanDone;
    logic       keyPresent;

    // hits saturates at 2: anything beyond one low bit per scan is a ghost
    always_comb begin
        lowBits  = ~rowSync_q;
        colLows  = 3'(lowBits[0]) + 3'(lowBits[1]) + 3'(lowBits[2]) + 3'(lowBits[3]);
        rowIdx   = 2'd0;
        if (lowBits[0])      rowIdx = 2'd0;
        else if (lowBits[1]) rowIdx = 2'd1;
        else if (lowBits[2]) rowIdx = 2'd2;
        else if (lowBits[3]) rowIdx = 2'd3;
        hitsSum    = 3'(hits_q) + colLows;
        hitsNext   = (hitsSum >= 3'd2) ? 2'd2 : hitsSum[1:0];
        codeNext   = (colLows == 3'd1) ? keyMap(colIdx_q, rowIdx) : codeAcc_q;
        scanDone   = (div_q == DIV_LAST) && (colIdx_q == 2'd3);
        keyPresent = (hitsNext == 2'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rowMeta_q <= 4'hF;
            rowSync_q <= 4'hF;
            div_q     <= '0;
            colIdx_q  <= 2'd0;
            hits_q    <= 2'd0;
            codeAcc_q <= 4'h0;
        end else begin
            rowMeta_q <= row_i;
            rowSync_q <= rowMeta_q;
            if (div_q == DIV_LAST) begin
                div_q    <= '0;
                colIdx_q <= colIdx_q + 2'd1;
                if (colIdx_q == 2'd3) begin
                    hits_q    <= 2'd0;
                    codeAcc_q <= 4'h0;
                end else begin
                    hits_q    <= hitsNext;
                    codeAcc_q <= codeNext;
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    // With a single required scan the candidate and release stages collapse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cand_q     <= 4'h0;
            keyValid_q <= 1'b0;
            keyCode_q  <= 4'h0;
        end else begin
            keyValid_q <= 1'b0;
            if (scanDone) begin
                case (state_q)
                    IDLE: begin
                        if (keyPresent) begin
                            cand_q <= codeNext;
                            if (CNT_DONE == CNT_W'(1)) begin
                                state_q    <= PRESSED;
                                cnt_q      <= '0;
                                keyValid_q <= 1'b1;
                                keyCode_q  <= codeNext;
                            end else begin
                                state_q <= CAND;
                                cnt_q   <= CNT_W'(1);
                            end
                        end
                    end
                    CAND: begin
                        if (!keyPresent) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (codeNext != cand_q) begin
                            cand_q <= codeNext;
                            cnt_q  <= CNT_W'(1);
                        end else if (cnt_q + CNT_W'(1) == CNT_DONE) begin
                            state_q    <= PRESSED;
                            cnt_q      <= '0;
                            keyValid_q <= 1'b1;
                            keyCode_q  <= cand_q;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (!keyPresent) begin
                            if (CNT_DONE == CNT_W'(1)) begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= REL;
                                cnt_q   <= CNT_W'(1);
                            end
                        end
                    end
                    REL: begin
                        if (keyPresent) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                        end else if (cnt_q + CNT_W'(1) == CNT_DONE) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign col_o      = ~(4'b0001 << colIdx_q);
    assign keyValid_o = keyValid_q;
    assign keyCode_o  = keyCode_q;

endmodule

// File: rtl/keypad_bpm_entry.sv
// Keypad-driven two-digit BPM entry: shifts digits into the display pair,
// clears on A and commits tens*10+ones to the metronome on E.
module keypad_bpm_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int DEFAULT_BPM    = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] DispVal,
    output logic [3:0] DispVal2,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [6:0] bpm_out,
    output logic       bpm_valid
);

    logic       keyValid;
    logic [3:0] keyCode;

    logic [3:0] dispTens_q, dispTens_d;
    logic [3:0] dispOnes_q, dispOnes_d;
    logic [6:0] bpm_q, bpm_d;
    logic       bpmValid_q, bpmValid_d;

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_scanner (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_o     (col),
        .row_i     (row),
        .keyValid_o(keyValid),
        .keyCode_o (keyCode)
    );

    // Enter keeps the digits so the same value can be re-committed or edited
    always_comb begin
        dispTens_d = dispTens_q;
        dispOnes_d = dispOnes_q;
        bpm_d      = bpm_q;
        bpmValid_d = 1'b0;
        if (keyValid) begin
            if (keyCode <= 4'd9) begin
                dispTens_d = dispOnes_q;
                dispOnes_d = keyCode;
            end else if (keyCode == KEY_CLEAR) begin
                dispTens_d = 4'd0;
                dispOnes_d = 4'd0;
            end else if (keyCode == KEY_ENTER) begin
                bpm_d      = 7'(dispTens_q) * 7'd10 + 7'(dispOnes_q);
                bpmValid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dispTens_q <= 4'd0;
            dispOnes_q <= 4'd0;
            bpm_q      <= 7'(DEFAULT_BPM);
            bpmValid_q <= 1'b0;
        end else begin
            dispTens_q <= dispTens_d;
            dispOnes_q <= dispOnes_d;
            bpm_q      <= bpm_d;
            bpmValid_q <= bpmValid_d;
        end
    end

    assign DispVal   = dispTens_q;
    assign DispVal2  = dispOnes_q;
    assign key_valid = keyValid;
    assign key_code  = keyCode;
    assign bpm_out   = bpm_q;
    assign bpm_valid = bpmValid_q;

endmodule

// File: tb/tb_keypad_bpm_entry.sv
// Self-checking bench for keypad_bpm_entry: a keypad model drives rows from the
// scanned column, and a per-scan reference model predicts presses, digits and BPM.
module tb_keypad_bpm_entry;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;
    localparam int DEF_BPM  = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] col, row, DispVal, DispVal2, key_code;
    logic       key_valid, bpm_valid;
    logic [6:0] bpm_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] keysDown = '0;
    int gotKeyQ[$], expKeyQ[$], gotBpmQ[$], expBpmQ[$];

    bit armed;
    int runCode, runLen, relLen, expTens, expOnes, expBpm;

    always #5 clk = ~clk;

    keypad_bpm_entry #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEB),
        .DEFAULT_BPM   (DEF_BPM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .col      (col),
        .row      (row),
        .DispVal  (DispVal),
        .DispVal2 (DispVal2),
        .key_valid(key_valid),
        .key_code (key_code),
        .bpm_out  (bpm_out),
        .bpm_valid(bpm_valid)
    );

    // Physical keypad: which key sits at column c, row r
    function automatic int keyAt(input int c, input int r);
        case (c * 4 + r)
            0: return 1;   1: return 4;   2: return 7;   3: return 0;
            4: return 2;   5: return 5;   6: return 8;   7: return 15;
            8: return 3;   9: return 6;  10: return 9;  11: return 14;
            12: return 10; 13: return 11; 14: return 12; default: return 13;
        endcase
    endfunction

    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col[c] && keysDown[keyAt(c, r)]) row[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid) gotKeyQ.push_back(int'(key_code));
            if (bpm_valid) gotBpmQ.push_back(int'(bpm_out));
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void modelReset();
        armed = 1; runLen = 0; relLen = 0; runCode = 0;
        expTens = 0; expOnes = 0; expBpm = DEF_BPM;
    endfunction

    function automatic void modelEvent(input int code);
        expKeyQ.push_back(code);
        if (code <= 9) begin
            expTens = expOnes; expOnes = code;
        end else if (code == 10) begin
            expTens = 0; expOnes = 0;
        end else if (code == 14) begin
            expBpm = expTens * 10 + expOnes;
            expBpmQ.push_back(expBpm);
        end
    endfunction

    // One completed scan: a single held key is a hit, none or several is nothing
    function automatic void modelScan(input logic [15:0] keys);
        int res;
        res = -1;
        if ($countones(keys) == 1)
            for (int k = 0; k < 16; k++) if (keys[k]) res = k;
        if (armed) begin
            if (res < 0) runLen = 0;
            else if (runLen > 0 && res == runCode) runLen++;
            else begin runCode = res; runLen = 1; end
            if (runLen >= DEB) begin
                armed = 0; relLen = 0; modelEvent(runCode);
            end
        end else begin
            if (res < 0) begin
                relLen++;
                if (relLen >= DEB) begin armed = 1; runLen = 0; end
            end else relLen = 0;
        end
    endfunction

    task automatic waitBoundary();
        logic [3:0] p;
        int n;
        p = col;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (p == 4'b0111 && col == 4'b1110) break;
            p = col;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("[TB] FAIL scan_boundary: col=%b, required a scan wrap within 100 cycles", col);
        end
    endtask

    // Hold a key set for exactly one full scan, starting at a scan boundary
    task automatic applyStimulus(input logic [15:0] keys);
        keysDown = keys;
        waitBoundary();
        modelScan(keys);
    endtask

    task automatic pressKey(input int code, input int hold, input int rel);
        logic [15:0] m;
        m = 16'h1 << code;
        repeat (hold) applyStimulus(m);
        repeat (rel) applyStimulus(16'h0);
    endtask

    task automatic clearQueues();
        gotKeyQ.delete(); expKeyQ.delete(); gotBpmQ.delete(); expBpmQ.delete();
    endtask

    task automatic test_reset();
        logic [3:0] expCol;
        rst_n = 1'b0; keysDown = '0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (col !== 4'b1110) begin errors++; $display("[TB] FAIL reset_col: got %b, expected 1110", col); end
        if (DispVal !== 4'd0) begin errors++; $display("[TB] FAIL reset_tens: got %0d, expected 0", DispVal); end
        if (DispVal2 !== 4'd0) begin errors++; $display("[TB] FAIL reset_ones: got %0d, expected 0", DispVal2); end
        if (key_code !== 4'd0) begin errors++; $display("[TB] FAIL reset_code: got %0d, expected 0", key_code); end
        if (bpm_out !== 7'd60) begin errors++; $display("[TB] FAIL reset_bpm: got %0d, expected 60", bpm_out); end
        if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_valid: got %b, expected 0", key_valid); end
        if (bpm_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_bpm_valid: got %b, expected 0", bpm_valid); end
        rst_n = 1'b1;
        modelReset();
        clearQueues();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            expCol = ~(4'b0001 << (i / SCAN_DIV));
            checks++;
            if (col !== expCol) begin
                errors++; $display("[TB] FAIL col_sequence[%0d]: got %b, expected %b", i, col, expCol);
            end
        end
        applyStimulus(16'h0);
    endtask

    task automatic test_entry_commit();
        clearQueues();
        pressKey(1, 2, 2);
        pressKey(2, 2, 2);
        pressKey(14, 2, 2);
        checks += 5;
        if (gotKeyQ.size() != 3) begin errors++; $display("[TB] FAIL entry_key_count: got %0d, expected 3", gotKeyQ.size()); end
        if (DispVal !== 4'd1) begin errors++; $display("[TB] FAIL entry_tens: got %0d, expected 1", DispVal); end
        if (DispVal2 !== 4'd2) begin errors++; $display("[TB] FAIL entry_ones: got %0d, expected 2", DispVal2); end
        if (bpm_out !== 7'd12) begin errors++; $display("[TB] FAIL entry_bpm: got %0d, expected 12", bpm_out); end
        if (gotBpmQ.size() != 1) begin errors++; $display("[TB] FAIL entry_bpm_pulses: got %0d, expected 1", gotBpmQ.size()); end
        foreach (expKeyQ[i]) if (i < gotKeyQ.size()) begin
            checks++;
            if (gotKeyQ[i] != expKeyQ[i]) begin errors++; $display("[TB] FAIL entry_code[%0d]: got %0h, expected %0h", i, gotKeyQ[i], expKeyQ[i]); end
        end
    endtask

    task automatic test_bounce();
        clearQueues();
        pressKey(5, 1, 1);
        pressKey(5, 3, 2);
        checks += 3;
        if (gotKeyQ.size() != 1) begin errors++; $display("[TB] FAIL bounce_count: got %0d, expected 1", gotKeyQ.size()); end
        else if (gotKeyQ[0] != 5) begin errors++; $display("[TB] FAIL bounce_code: got %0h, expected 5", gotKeyQ[0]); end
        if (gotKeyQ.size() != expKeyQ.size()) begin errors++; $display("[TB] FAIL bounce_model_count: got %0d, expected %0d", gotKeyQ.size(), expKeyQ.size()); end
        if (DispVal2 !== 4'(expOnes)) begin errors++; $display("[TB] FAIL bounce_ones: got %0d, expected %0d", DispVal2, expOnes); end
    endtask

    task automatic test_ghost();
        clearQueues();
        repeat (5) applyStimulus(16'h0006);
        checks++;
        if (gotKeyQ.size() != 0) begin errors++; $display("[TB] FAIL ghost_suppressed: got %0d presses, expected 0", gotKeyQ.size()); end
        pressKey(1, 3, 2);
        checks += 2;
        if (gotKeyQ.size() != 1) begin errors++; $display("[TB] FAIL ghost_release_count: got %0d, expected 1", gotKeyQ.size()); end
        else if (gotKeyQ[0] != 1) begin errors++; $display("[TB] FAIL ghost_release_code: got %0h, expected 1", gotKeyQ[0]); end
        if (gotKeyQ.size() != expKeyQ.size()) begin errors++; $display("[TB] FAIL ghost_model_count: got %0d, expected %0d", gotKeyQ.size(), expKeyQ.size()); end
    endtask

    task automatic test_shift_clear();
        clearQueues();
        pressKey(9, 2, 2);
        pressKey(8, 2, 2);
        pressKey(7, 2, 2);
        checks += 2;
        if (DispVal !== 4'd8) begin errors++; $display("[TB] FAIL shift_tens: got %0d, expected 8", DispVal); end
        if (DispVal2 !== 4'd7) begin errors++; $display("[TB] FAIL shift_ones: got %0d, expected 7", DispVal2); end
        pressKey(10, 2, 2);
        checks += 2;
        if (DispVal !== 4'd0) begin errors++; $display("[TB] FAIL clear_tens: got %0d, expected 0", DispVal); end
        if (DispVal2 !== 4'd0) begin errors++; $display("[TB] FAIL clear_ones: got %0d, expected 0", DispVal2); end
        pressKey(14, 2, 2);
        checks += 2;
        if (bpm_out !== 7'd0) begin errors++; $display("[TB] FAIL clear_commit_bpm: got %0d, expected 0", bpm_out); end
        if (gotBpmQ.size() != 1) begin errors++; $display("[TB] FAIL clear_commit_pulses: got %0d, expected 1", gotBpmQ.size()); end
    endtask

    task automatic test_reset_during_hold();
        clearQueues();
        repeat (2) applyStimulus(16'h0010);
        repeat ($urandom_range(2, 12)) @(negedge clk);
        checks += 2;
        if (gotKeyQ.size() != 1) begin errors++; $display("[TB] FAIL hold_pre_count: got %0d, expected 1", gotKeyQ.size()); end
        if (DispVal2 !== 4'd4) begin errors++; $display("[TB] FAIL hold_pre_ones: got %0d, expected 4", DispVal2); end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 2;
        if (bpm_out !== 7'd60) begin errors++; $display("[TB] FAIL hold_reset_bpm: got %0d, expected 60", bpm_out); end
        if (DispVal2 !== 4'd0) begin errors++; $display("[TB] FAIL hold_reset_ones: got %0d, expected 0", DispVal2); end
        rst_n = 1'b1;
        modelReset();
        clearQueues();
        repeat (3) applyStimulus(16'h0010);
        repeat (2) applyStimulus(16'h0);
        checks += 3;
        if (gotKeyQ.size() != 1) begin errors++; $display("[TB] FAIL hold_post_count: got %0d, expected 1", gotKeyQ.size()); end
        else if (gotKeyQ[0] != 4) begin errors++; $display("[TB] FAIL hold_post_code: got %0h, expected 4", gotKeyQ[0]); end
        if (DispVal2 !== 4'd4) begin errors++; $display("[TB] FAIL hold_post_ones: got %0d, expected 4", DispVal2); end
        if (DispVal !== 4'd0) begin errors++; $display("[TB] FAIL hold_post_tens: got %0d, expected 0", DispVal); end
    endtask

    task automatic test_random();
        logic [15:0] m;
        clearQueues();
        for (int n = 0; n < 24; n++) begin
            m = 16'h1 << $urandom_range(0, 15);
            if ($urandom_range(0, 5) == 0) m = m | (16'h1 << $urandom_range(0, 15));
            repeat ($urandom_range(1, 4)) applyStimulus(m);
            repeat ($urandom_range(1, 3)) applyStimulus(16'h0);
        end
        repeat (2) applyStimulus(16'h0);
        checks += 5;
        if (gotKeyQ.size() != expKeyQ.size()) begin errors++; $display("[TB] FAIL rand_key_count: got %0d, expected %0d", gotKeyQ.size(), expKeyQ.size()); end
        if (gotBpmQ.size() != expBpmQ.size()) begin errors++; $display("[TB] FAIL rand_bpm_count: got %0d, expected %0d", gotBpmQ.size(), expBpmQ.size()); end
        if (DispVal !== 4'(expTens)) begin errors++; $display("[TB] FAIL rand_tens: got %0d, expected %0d", DispVal, expTens); end
        if (DispVal2 !== 4'(expOnes)) begin errors++; $display("[TB] FAIL rand_ones: got %0d, expected %0d", DispVal2, expOnes); end
        if (bpm_out !== 7'(expBpm)) begin errors++; $display("[TB] FAIL rand_bpm: got %0d, expected %0d", bpm_out, expBpm); end
        foreach (expKeyQ[i]) if (i < gotKeyQ.size()) begin
            checks++;
            if (gotKeyQ[i] != expKeyQ[i]) begin errors++; $display("[TB] FAIL rand_code[%0d]: got %0h, expected %0h", i, gotKeyQ[i], expKeyQ[i]); end
        end
        foreach (expBpmQ[i]) if (i < gotBpmQ.size()) begin
            checks++;
            if (gotBpmQ[i] != expBpmQ[i]) begin errors++; $display("[TB] FAIL rand_bpm_value[%0d]: got %0d, expected %0d", i, gotBpmQ[i], expBpmQ[i]); end
        end
    endtask

    initial begin
        $display("[TB] keypad_bpm_entry bench start");
        test_reset();
        test_entry_commit();
        test_bounce();
        test_ghost();
        test_shift_clear();
        test_reset_during_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_bpm_entry.md
Name: keypad_bpm_entry

Overview:
- Producer side of the digit-display interface. Scans the 4x4 Pmod keypad, debounces presses, and accumulates a two-digit BPM value.
- Presents the tens digit on DispVal and the ones digit on DispVal2 for the seven-segment display controller.
- Commits the entered BPM to the metronome on the Enter key.
- Sits between the keypad pins and the display/metronome blocks.

Parameters:
- SCAN_DIV, 1000: clk cycles each column is driven before its rows are sampled. Minimum 4.
- DEBOUNCE_SCANS, 4: consecutive full 4-column scans that must agree before a press or release is accepted. Minimum 1.
- DEFAULT_BPM, 60: bpm_out value after reset. Range 0..99.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- col  output  4  keypad column drive, active-low, exactly one bit low
- row  input  4  keypad row sense, active-low (pulled up), asynchronous to clk
- DispVal  output  4  tens digit being entered, 0..9
- DispVal2  output  4  ones digit being entered, 0..9
- key_valid  output  1  one-cycle pulse on each accepted press
- key_code  output  4  code of the last accepted key, held between pulses
- bpm_out  output  7  committed BPM, 0..99
- bpm_valid  output  1  one-cycle pulse when bpm_out is updated

Behaviour:
- Reset values (asynchronous on rst_n low):
  - col = 4'b1110; DispVal = 0; DispVal2 = 0; key_code = 0; bpm_out = DEFAULT_BPM.
  - key_valid = 0; bpm_valid = 0; all counters = 0; debounce FSM = IDLE.
- Row synchroniser: row passes through a 2-flop synchroniser before any use.
- Column scan:
  - Column index c cycles 0, 1, 2, 3, 0, ...; col = ~(1<<c).
  - Each column is held SCAN_DIV cycles. Synchronised rows are sampled on the last hold cycle, then c advances.
  - Scan completes after the column-3 sample.
- Per-scan result:
  - Exactly one sampled low row bit across all 4 columns: key present, code from the keymap.
  - Zero low bits: no key.
  - Two or more low bits: ghost, treated as no key.
- Keymap, col/row -> code:
  - c0 rows 0..3 = 1, 4, 7, 0
  - c1 rows 0..3 = 2, 5, 8, F
  - c2 rows 0..3 = 3, 6, 9, E
  - c3 rows 0..3 = A, B, C, D
- Debounce FSM, evaluated once per completed scan:
  - IDLE: key present -> CAND, cnt = 1, cand = code.
  - CAND:
    - Same code -> cnt+1.
    - cnt reaching DEBOUNCE_SCANS -> PRESSED. key_valid pulses on the following cycle; key_code = cand.
    - Different code -> restart CAND with the new code.
    - No key -> IDLE.
  - PRESSED: no key -> REL, cnt = 1. Any key (including a different one) -> stay PRESSED; no second event until release.
  - REL:
    - No key -> cnt+1; cnt reaching DEBOUNCE_SCANS -> IDLE.
    - Key present -> PRESSED.
  - With DEBOUNCE_SCANS = 1, CAND is passed through on the first scan.
- Entry logic, acting in the same cycle as key_valid:
  - Keys 0..9: DispVal <= DispVal2; DispVal2 <= key. This is a shift-left entry; older digits are dropped.
  - Key A (clear): DispVal = DispVal2 = 0.
  - Key E (enter): bpm_out <= DispVal*10 + DispVal2 (7-bit, max 99); bpm_valid pulses in the same cycle as the bpm_out update. Digits are not cleared.
  - Keys B, C, D, F: key_valid still pulses; no other effect.
- Latency: a clean press held from a scan boundary produces key_valid 1 cycle after the end of scan number DEBOUNCE_SCANS. Minimum press-to-pulse time is DEBOUNCE_SCANS*4*SCAN_DIV + 3 cycles, including the synchroniser.
- Reset mid-scan or mid-debounce: all state returns to reset values immediately. A key still held after reset is re-debounced from IDLE and produces one press.

Decomposition:
- Package keypad_pkg:
  - Key code constants: KEY_CLEAR = 4'hA, KEY_ENTER = 4'hE.
  - Debounce state typedef: IDLE, CAND, PRESSED, REL.
  - Keymap function (col index, row index -> code).
- Sub-module keypad_scanner: synchroniser, column drive, per-scan decode, debounce FSM. Outputs key_valid and key_code.
- Top level: entry registers, BPM arithmetic, bpm_valid.

Test Plan (SCAN_DIV = 4, DEBOUNCE_SCANS = 2):
- Reset: rst_n low -> col = 1110, DispVal = 0, DispVal2 = 0, bpm_out = 60, no pulses. col sequence after reset is 1110, 1101, 1011, 0111, 4 cycles each.
- Entry and commit: press "1", release; press "2", release; press "E" -> key_valid x3. DispVal = 1, DispVal2 = 2. bpm_out = 12 with a single bpm_valid pulse.
- Bounce: "5" row toggled for 1 scan, released, then held 3 scans -> exactly one key_valid with code 5. None for the 1-scan glitch.
- Ghost: "1" and "2" held together for 5 scans -> no key_valid. Releasing "2" -> one key_valid with code 1 after 2 scans.
- Shift and clear: enter "9", "8", "7" -> DispVal = 8, DispVal2 = 7. Press "A" -> both 0. Press "E" -> bpm_out = 0.
- Reset during hold: rst_n pulsed while "4" is in PRESSED, key still held -> after reset, one new key_valid with code 4 and DispVal2 = 4.
